// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs PACK show-ahead FIFO words into one wide valid/ready word, with flush for partial words
module fifo_word_packer #(
    parameter int BITWIDTH = 5,
    parameter int PACK     = 4,
    parameter int CNTW     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_empty,
    input  logic [BITWIDTH-1:0]      fifo_dout,
    output logic                     fifo_rd,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITWIDTH*PACK-1:0] out_data,
    output logic [CNTW-1:0]          out_count,
    output logic                     out_last
);

    localparam int W = BITWIDTH * PACK;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] filled;
    logic [W-1:0]    lanes_q, lanes_d;
    logic            flush_pend_q, flush_pend_d;
    logic            out_valid_d;
    logic [W-1:0]    out_data_d;
    logic [CNTW-1:0] out_count_d;
    logic            out_last_d;
    logic            pop;
    logic            flush_req;

    // Pop only while filling; never pop an empty FIFO or during reset.
    assign fifo_rd   = (state_q == FILL) && !fifo_empty && !rst;
    assign pop       = fifo_rd;
    assign flush_req = flush | flush_pend_q;
    assign filled    = cnt_q + CNTW'(pop);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lanes_d      = lanes_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid;
        out_data_d   = out_data;
        out_count_d  = out_count;
        out_last_d   = out_last;

        case (state_q)
            FILL: begin
                if (pop) begin
                    lanes_d[int'(cnt_q)*BITWIDTH +: BITWIDTH] = fifo_dout;
                    cnt_d = filled;
                end
                if (pop && (cnt_q == CNTW'(PACK - 1))) begin
                    state_d      = HOLD;
                    cnt_d        = '0;
                    out_valid_d  = 1'b1;
                    out_data_d   = lanes_d;
                    out_count_d  = CNTW'(PACK);
                    out_last_d   = flush_req;
                    flush_pend_d = 1'b0;
                end else if (flush_req) begin
                    // A flush with nothing packed is simply dropped.
                    flush_pend_d = 1'b0;
                    if (filled != '0) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = lanes_d;
                        out_count_d = filled;
                        out_last_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (out_ready) begin
                    state_d     = FILL;
                    cnt_d       = '0;
                    lanes_d     = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            lanes_q      <= '0;
            flush_pend_q <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_count    <= '0;
            out_last     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lanes_q      <= lanes_d;
            flush_pend_q <= flush_pend_d;
            out_valid    <= out_valid_d;
            out_data     <= out_data_d;
            out_count    <= out_count_d;
            out_last     <= out_last_d;
        end
    end

endmodule
